buzzer_tone_driver: RTL and testbench
=====================================

BUZZER_TONE_DRIVER -- requirements
Module: buzzer_tone_driver

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 100_000_000, SHALL give the clock rate in Hz used to build the half-period table.
REQ-002 Parameter NOTE_COUNT, default 36, SHALL give the number of valid note indices, 0..NOTE_COUNT-1.
REQ-003 Port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port frequency_select, input, 32 bits: requested note index; all-ones (~0) means silence.
REQ-006 Port buzzer, output, 1 bit: square-wave drive to the piezo or speaker.
REQ-007 Port active, output, 1 bit: high while a tone is being generated.
REQ-008 Port current_note, output, 6 bits: index of the note currently sounding; holds its last value while idle.

Function
REQ-009 frequency_select SHALL be registered once on entry, and all decisions SHALL use the registered copy (req).
REQ-010 Any req value >= NOTE_COUNT, including ~0, SHALL be treated as silence.
REQ-011 The half-period table SHALL be HALF(k) = round(CLOCK_FREQUENCY / (2 * 220 * 2^(k/12))) cycles, with index 0 = 220 Hz, and SHALL be computed at elaboration.
REQ-012 At default parameters: HALF(0)=227273, HALF(12)=113636, HALF(35)=30098.
REQ-013 The phase counter SHALL be 20 bits wide, and elaboration SHALL fail if HALF(0) exceeds 2^20.
REQ-014 The controller SHALL have two states: IDLE and PLAY.
REQ-015 In IDLE with req a valid note k, the block SHALL enter PLAY on the next edge with buzzer=1, counter=0, current_note=k, active=1.
REQ-016 From a frequency_select change, buzzer SHALL rise on the second rising edge.
REQ-017 In PLAY, the counter SHALL increment each cycle; at counter == HALF(current_note)-1 (the boundary), buzzer SHALL toggle and the counter SHALL clear.
REQ-018 In PLAY, a req equal to current_note SHALL have no effect; the phase SHALL NOT restart.
REQ-019 In PLAY, a new valid note SHALL be applied only at the next boundary: buzzer toggles, current_note loads, and the following half-period uses the new HALF.
REQ-020 This rule SHALL prevent runt pulses.
REQ-021 In PLAY with req = silence and buzzer=0, the block SHALL enter IDLE on the next edge with active=0 and buzzer=0.
REQ-022 In PLAY with req = silence and buzzer=1, the block SHALL continue to the boundary, then set buzzer=0, active=0 and enter IDLE.
REQ-023 The most recent req at a boundary SHALL win; intermediate requests that change again before a boundary SHALL be ignored.
REQ-024 If req returns to current_note before the boundary, any pending change SHALL be cancelled.
REQ-025 In IDLE, buzzer SHALL be 0 and the counter SHALL be held at 0.
REQ-026 All outputs SHALL be driven directly from registers, with no combinational path from frequency_select to any output.

Reset
REQ-027 While reset=1, the block SHALL immediately (asynchronously) force buzzer=0, active=0, current_note=0, counter=0, req=silence and state=IDLE.
REQ-028 After reset is released, the first valid note SHALL obey REQ-015/REQ-016.
REQ-029 A reset asserted mid-tone SHALL discard any pending note change.

Verification
REQ-030 Reset: assert reset mid-PLAY at an arbitrary clock phase -> buzzer, active and current_note are 0 before the next clock edge; then release with frequency_select=~0 -> outputs stay 0 for 1000 cycles.
REQ-031 Start tone: from IDLE, set frequency_select=12 -> buzzer=1 on the 2nd edge, current_note=12, and buzzer is high for 113636 cycles and low for 113636 cycles, repeating.
REQ-032 Note change: while note 12 is high, 50000 cycles into the phase, set frequency_select=0 -> the high phase still lasts 113636 cycles total, then the low phase lasts 227273 cycles and current_note=0 from the boundary.
REQ-033 Silence: during the note-35 high phase, set ~0 -> buzzer falls at the 30098-cycle boundary and active drops on the same edge; during a low phase, set ~0 -> active=0 two edges after the change and buzzer stays 0.
REQ-034 Out of range: set frequency_select=36 in IDLE -> stays IDLE; set 36 while playing -> behaves exactly as ~0.
REQ-035 Glitch filter: toggle 12->20->12 within one half-period -> no change to current_note or phase timing; a sequence 3->7->9 ending before a boundary -> only 9 is applied at that boundary.

Source files
------------

// File: rtl/buzzer_tone_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : buzzer_tone_driver
// Purpose  : Square-wave tone generator for a piezo buzzer or small speaker.
//            Plays one note from an equal-tempered table (index 0 = 220 Hz,
//            12 notes per octave). Note changes and silencing are applied only
//            at half-period boundaries, so the output never produces runt
//            pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   1   system clock, rising-edge active
//   reset            in   1   asynchronous, active-high reset
//   frequency_select in  32   requested note index; all-ones means silence
//   buzzer           out  1   square-wave drive
//   active           out  1   high while a tone is being generated
//   current_note     out  6   index of the sounding note (held while idle)
// ============================================================================
module buzzer_tone_driver #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int NOTE_COUNT      = 36
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] frequency_select,
  output logic        buzzer,
  output logic        active,
  output logic [5:0]  current_note
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [31:0] C_SILENCE   = '1;
  localparam int          C_CNT_W     = 20;
  localparam longint      C_CNT_LIMIT = 64'd1 << C_CNT_W;

  // Half-period in clock cycles for note k, rounded to nearest.
  function automatic int unsigned half_calc(input int k);
    real f_note;
    f_note = 220.0 * (2.0 ** (real'(k) / 12.0));
    return int'($rtoi((real'(CLOCK_FREQUENCY) / (2.0 * f_note)) + 0.5));
  endfunction

  // The lowest note has the longest half-period; it must fit the counter.
  // The highest note must still have a non-zero half-period.
  generate
    if (longint'(half_calc(0)) > C_CNT_LIMIT) begin : g_half_too_long
      $error("buzzer_tone_driver: HALF(0) exceeds the 20-bit phase counter");
    end
    if (half_calc(NOTE_COUNT - 1) < 1) begin : g_half_too_short
      $error("buzzer_tone_driver: highest note half-period rounds to zero");
    end
    if (NOTE_COUNT > 64 || NOTE_COUNT < 1) begin : g_note_count_range
      $error("buzzer_tone_driver: NOTE_COUNT must be 1..64");
    end
  endgenerate

  // Constant half-period table, one entry per note.
  logic [C_CNT_W-1:0] w_half_tab [NOTE_COUNT];

  generate
    for (genvar k = 0; k < NOTE_COUNT; k++) begin : g_half_table
      localparam int unsigned C_HALF = half_calc(k);
      assign w_half_tab[k] = C_CNT_W'(C_HALF);
    end
  endgenerate

  state_t             state_q, state_d;
  logic [31:0]        req_q;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic               buzzer_q, buzzer_d;
  logic               active_q, active_d;
  logic [5:0]         note_q, note_d;

  logic               w_req_valid;
  logic               w_boundary;

  // Anything outside the table (including all-ones) means silence.
  assign w_req_valid = (req_q < 32'(NOTE_COUNT));
  assign w_boundary  = (count_q == (w_half_tab[note_q] - C_CNT_W'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= C_SILENCE;
      count_q  <= '0;
      buzzer_q <= 1'b0;
      active_q <= 1'b0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= frequency_select;
      count_q  <= count_d;
      buzzer_q <= buzzer_d;
      active_q <= active_d;
      note_q   <= note_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    buzzer_d = buzzer_q;
    active_d = active_q;
    note_d   = note_q;

    case (state_q)
      ST_IDLE: begin
        count_d  = '0;
        buzzer_d = 1'b0;
        active_d = 1'b0;
        if (w_req_valid) begin
          state_d  = ST_PLAY;
          buzzer_d = 1'b1;
          active_d = 1'b1;
          note_d   = req_q[5:0];
        end
      end

      ST_PLAY: begin
        if (!w_req_valid && !buzzer_q) begin
          // Output already low: stopping now cannot truncate a pulse.
          state_d  = ST_IDLE;
          active_d = 1'b0;
          count_d  = '0;
        end else if (w_boundary) begin
          count_d = '0;
          if (!w_req_valid) begin
            // End of a high phase: finish low and stop.
            state_d  = ST_IDLE;
            buzzer_d = 1'b0;
            active_d = 1'b0;
          end else begin
            // Whatever is requested now wins; earlier requests are forgotten.
            buzzer_d = ~buzzer_q;
            note_d   = req_q[5:0];
          end
        end else begin
          count_d = count_q + C_CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        count_d  = '0;
        buzzer_d = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  assign buzzer       = buzzer_q;
  assign active       = active_q;
  assign current_note = note_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_tone_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_tone_driver
// Purpose  : Directed self-checking bench for buzzer_tone_driver. A scaled
//            instance (CLOCK_FREQUENCY = 100_000) keeps phases short; a
//            default-parameter instance checks one full-scale half-period.
//            Scaled half-periods: HALF(0)=227 HALF(9)=135 HALF(12)=114
//            HALF(20)=72 HALF(35)=30. Full scale: HALF(35)=30098.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_tone_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fs;
  logic [31:0] fs_def;
  logic        buzzer,  buzzer_def;
  logic        active,  active_def;
  logic [5:0]  current_note, note_def;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  buzzer_tone_driver #(
    .CLOCK_FREQUENCY (100_000),
    .NOTE_COUNT      (36)
  ) u_dut (
    .clock            (clock),
    .reset            (reset),
    .frequency_select (fs),
    .buzzer           (buzzer),
    .active           (active),
    .current_note     (current_note)
  );

  buzzer_tone_driver u_dut_def (
    .clock            (clock),
    .reset            (reset),
    .frequency_select (fs_def),
    .buzzer           (buzzer_def),
    .active           (active_def),
    .current_note     (note_def)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic skip(input int k);
    repeat (k) @(negedge clock);
  endtask

  // Called at a negedge: counts negedges until buzzer leaves its current level.
  task automatic run_level(output int n);
    logic lvl;
    lvl = buzzer;
    n   = 0;
    while (buzzer === lvl && n < 2000) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int n;
    int viol;

    reset  = 1'b1;
    fs     = '1;
    fs_def = '1;
    #2;
    check("rst_buzzer", 32'(buzzer), 0);
    check("rst_active", 32'(active), 0);
    check("rst_note",   32'(current_note), 0);

    skip(3);
    reset = 1'b0;
    skip(20);
    check("idle_active", 32'(active), 0);
    check("idle_buzzer", 32'(buzzer), 0);

    // Out-of-range request while idle.
    fs = 32'd36;
    skip(10);
    check("oor_idle_active", 32'(active), 0);
    check("oor_idle_buzzer", 32'(buzzer), 0);

    // Start note 12: buzzer rises on the second edge.
    fs = 32'd12;
    @(posedge clock); #1;
    check("start_edge1_buzzer", 32'(buzzer), 0);
    @(posedge clock); #1;
    check("start_edge2_buzzer", 32'(buzzer), 1);
    check("start_active", 32'(active), 1);
    check("start_note", 32'(current_note), 12);
    @(negedge clock);
    run_level(n); check("n12_high", 32'(n), 114);
    run_level(n); check("n12_low",  32'(n), 114);

    // Note change 50 cycles into a high phase: applied at the boundary.
    skip(50);
    fs = 32'd0;
    run_level(n); check("chg_high_total", 32'(50 + n), 114);
    check("chg_note", 32'(current_note), 0);
    run_level(n); check("chg_low", 32'(n), 227);
    run_level(n); check("n0_high", 32'(n), 227);

    // Glitch that returns to the current note before the boundary.
    skip(10); fs = 32'd12;
    skip(10); fs = 32'd20;
    skip(10); fs = 32'd0;
    run_level(n); check("glitch_phase", 32'(30 + n), 227);
    check("glitch_note", 32'(current_note), 0);
    run_level(n); check("glitch_next", 32'(n), 227);

    // 3 -> 7 -> 9 within one phase: only 9 lands.
    skip(10); fs = 32'd3;
    skip(10); fs = 32'd7;
    skip(10); fs = 32'd9;
    run_level(n); check("seq_phase", 32'(30 + n), 227);
    check("seq_note", 32'(current_note), 9);
    run_level(n); check("seq_next", 32'(n), 135);

    // Move to note 35 at the start of a low phase.
    fs = 32'd35;
    run_level(n); check("to35_phase", 32'(n), 135);
    check("to35_note", 32'(current_note), 35);
    check("n35_high_level", 32'(buzzer), 1);

    // Silence during high: high completes, active drops on the same edge.
    skip(10);
    fs = '1;
    run_level(n); check("sil_high_total", 32'(10 + n), 30);
    check("sil_high_active", 32'(active), 0);
    check("sil_high_buzzer", 32'(buzzer), 0);

    // Silence during low: active drops two edges after the change.
    fs = 32'd35;
    @(posedge clock); @(posedge clock); #1;
    check("restart35_buzzer", 32'(buzzer), 1);
    @(negedge clock);
    run_level(n); check("n35_high2", 32'(n), 30);
    skip(5);
    fs = '1;
    @(posedge clock); #1;
    check("sil_low_edge1_active", 32'(active), 1);
    @(posedge clock); #1;
    check("sil_low_edge2_active", 32'(active), 0);
    check("sil_low_edge2_buzzer", 32'(buzzer), 0);
    @(negedge clock);

    // Out-of-range while playing behaves as silence.
    fs = 32'd12;
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("oor_play_start", 32'(buzzer), 1);
    skip(10);
    fs = 32'd36;
    run_level(n); check("oor_play_high", 32'(10 + n), 114);
    check("oor_play_active", 32'(active), 0);

    // Reset mid-tone with a change pending, off the clock edge.
    fs = 32'd20;
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("n20_note", 32'(current_note), 20);
    skip(30);
    fs = 32'd12;
    skip(3);
    #3 reset = 1'b1;
    #1;
    check("midrst_buzzer", 32'(buzzer), 0);
    check("midrst_active", 32'(active), 0);
    check("midrst_note",   32'(current_note), 0);
    fs = '1;
    @(negedge clock);
    reset = 1'b0;
    viol = 0;
    repeat (1000) begin
      @(negedge clock);
      if (buzzer !== 1'b0 || active !== 1'b0 || current_note !== 6'd0) viol++;
    end
    check("post_rst_quiet", 32'(viol), 0);

    // First note after reset.
    fs = 32'd20;
    @(posedge clock); #1;
    check("post_rst_edge1", 32'(buzzer), 0);
    @(posedge clock); #1;
    check("post_rst_edge2", 32'(buzzer), 1);
    check("post_rst_note", 32'(current_note), 20);
    @(negedge clock);
    run_level(n); check("n20_high", 32'(n), 72);

    // Full-scale instance: one half-period of note 35.
    fs_def = 32'd35;
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("def_note", 32'(note_def), 35);
    check("def_buzzer", 32'(buzzer_def), 1);
    n = 0;
    while (buzzer_def === 1'b1 && n < 40000) begin
      @(negedge clock);
      n++;
    end
    check("def_half35", 32'(n), 30098);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
